// File: rtl/clk_div_n_fsm_if.sv
// clk_div_n_fsm_if: control and status bundle for the divide-by-N generator
interface clk_div_n_fsm_if #(parameter int WIDTH = 8);
  logic             en;
  logic             stop;
  logic             mode;
  logic [WIDTH-1:0] div_in;
  logic             div_load;
  logic             y;
  logic             tick;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] div_cur;
  logic             pend;
  modport master (output en, stop, mode, div_in, div_load, input y, tick, count, div_cur, pend);
  modport slave  (input en, stop, mode, div_in, div_load, output y, tick, count, div_cur, pend);
endinterface

// File: rtl/clk_div_n_fsm.sv
// clk_div_n_fsm: divide-by-N enable generator with runtime divisor reload and pulse/square output
module clk_div_n_fsm #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 3
) (
  input logic           clk,
  input logic           reset,
  clk_div_n_fsm_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t           state;
  logic [WIDTH-1:0] count, div_cur, div_pend, load_val, last;
  logic [WIDTH:0]   half;
  logic             pend, run, wrap, apply;
  always_comb begin
    load_val = (bus.div_in == '0) ? WIDTH'(1) : bus.div_in;
    last     = div_cur - WIDTH'(1);
    half     = ({1'b0, div_cur} + (WIDTH+1)'(1)) >> 1;
    run      = state == RUN;
    wrap     = run && bus.en && count == last;
    apply    = !run || bus.stop || wrap;
  end
  // a same-cycle load bypasses div_pend so the freshly presented value is applied
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      div_cur  <= WIDTH'(DEFAULT_DIV);
      div_pend <= '0;
      pend     <= 1'b0;
    end else begin
      if (bus.div_load) div_pend <= load_val;
      if (apply && (bus.div_load || pend)) div_cur <= bus.div_load ? load_val : div_pend;
      pend <= !apply && (bus.div_load || pend);
      if (!run) begin
        state <= (bus.en && !bus.stop) ? RUN : IDLE;
        count <= '0;
      end else if (bus.stop) begin
        state <= IDLE;
        count <= '0;
      end else if (bus.en) count <= wrap ? '0 : count + WIDTH'(1);
    end
  assign bus.y       = run && (bus.mode ? ({1'b0, count} < half) : (count == '0));
  assign bus.tick    = wrap && !bus.stop;
  assign bus.count   = count;
  assign bus.div_cur = div_cur;
  assign bus.pend    = pend;
endmodule

// File: tb/tb_clk_div_n_fsm.sv
// tb_clk_div_n_fsm: directed scenario checks for clk_div_n_fsm
module tb_clk_div_n_fsm;
  logic clk, reset;
  int   pass_n, total_n;
  clk_div_n_fsm_if #(.WIDTH(8)) bus ();
  clk_div_n_fsm #(.WIDTH(8), .DEFAULT_DIV(3)) dut (.clk(clk), .reset(reset), .bus(bus));
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    else pass_n++;
  endtask
  task automatic rst_dut;
    reset = 1;
    bus.en = 0; bus.stop = 0; bus.mode = 0; bus.div_load = 0; bus.div_in = 0;
    cyc();
    cyc();
    reset = 0;
  endtask
  task automatic test_reset;
    rst_dut();
    chk("reset_y", bus.y, 0);
    chk("reset_tick", bus.tick, 0);
    chk("reset_count", bus.count, 0);
    chk("reset_div_cur", bus.div_cur, 3);
    chk("reset_pend", bus.pend, 0);
    cyc();
    chk("idle_hold_y", bus.y, 0);
  endtask
  task automatic test_default_divide;
    rst_dut();
    bus.en = 1;
    cyc();
    for (int i = 0; i < 9; i++) begin
      chk("def_count", bus.count, i % 3);
      chk("def_y", bus.y, (i % 3) == 0);
      chk("def_tick", bus.tick, (i % 3) == 2);
      cyc();
    end
  endtask
  task automatic test_reload;
    rst_dut();
    bus.en = 1;
    cyc();
    cyc();
    chk("rl_count1", bus.count, 1);
    bus.div_load = 1; bus.div_in = 5;
    cyc();
    bus.div_load = 0;
    #1;
    chk("rl_pend", bus.pend, 1);
    chk("rl_old_div", bus.div_cur, 3);
    chk("rl_tick_old", bus.tick, 1);
    cyc();
    chk("rl_new_div", bus.div_cur, 5);
    chk("rl_pend_clr", bus.pend, 0);
    for (int i = 0; i < 10; i++) begin
      chk("rl_count", bus.count, i % 5);
      chk("rl_y", bus.y, (i % 5) == 0);
      chk("rl_tick", bus.tick, (i % 5) == 4);
      cyc();
    end
  endtask
  task automatic test_reload_edges;
    rst_dut();
    bus.en = 1; bus.div_load = 1; bus.div_in = 0;
    cyc();
    bus.div_load = 0;
    #1;
    chk("zero_div_cur", bus.div_cur, 1);
    chk("zero_pend", bus.pend, 0);
    for (int i = 0; i < 4; i++) begin
      chk("n1_y", bus.y, 1);
      chk("n1_tick", bus.tick, 1);
      chk("n1_count", bus.count, 0);
      cyc();
    end
    rst_dut();
    bus.en = 1;
    cyc();
    cyc();
    cyc();
    bus.div_load = 1; bus.div_in = 4;
    #1;
    chk("wrap_ld_tick", bus.tick, 1);
    cyc();
    bus.div_load = 0;
    #1;
    chk("wrap_ld_div", bus.div_cur, 4);
    chk("wrap_ld_pend", bus.pend, 0);
    for (int i = 0; i < 4; i++) begin
      chk("wrap_ld_count", bus.count, i);
      chk("wrap_ld_tick4", bus.tick, i == 3);
      cyc();
    end
  endtask
  task automatic test_square;
    rst_dut();
    bus.mode = 1; bus.div_load = 1; bus.div_in = 4;
    cyc();
    bus.div_load = 0;
    #1;
    chk("sq_idle_div", bus.div_cur, 4);
    chk("sq_idle_y", bus.y, 0);
    bus.en = 1;
    cyc();
    for (int i = 0; i < 8; i++) begin
      chk("sq4_y", bus.y, (i % 4) < 2);
      cyc();
    end
    bus.stop = 1; bus.div_load = 1; bus.div_in = 5;
    cyc();
    bus.stop = 0; bus.div_load = 0;
    cyc();
    chk("sq5_div", bus.div_cur, 5);
    for (int i = 0; i < 10; i++) begin
      chk("sq5_y", bus.y, (i % 5) < 3);
      cyc();
    end
    cyc();
    bus.mode = 0;
    #1;
    chk("mode_to_pulse_y", bus.y, 0);
    bus.mode = 1;
    #1;
    chk("mode_to_square_y", bus.y, 1);
    bus.stop = 1; bus.div_load = 1; bus.div_in = 1;
    cyc();
    bus.stop = 0; bus.div_load = 0;
    cyc();
    for (int i = 0; i < 4; i++) begin
      chk("sq1_y", bus.y, 1);
      cyc();
    end
  endtask
  task automatic test_enable_gating;
    rst_dut();
    bus.en = 1;
    cyc();
    cyc();
    bus.en = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("gate_count", bus.count, 1);
      chk("gate_y", bus.y, 0);
      chk("gate_tick", bus.tick, 0);
    end
    bus.en = 1;
    cyc();
    chk("ungate_count", bus.count, 2);
    chk("ungate_tick", bus.tick, 1);
    cyc();
    chk("ungate_y", bus.y, 1);
  endtask
  task automatic test_stop;
    rst_dut();
    bus.en = 1;
    cyc();
    cyc();
    cyc();
    bus.stop = 1;
    #1;
    chk("stop_count", bus.count, 2);
    chk("stop_tick", bus.tick, 0);
    chk("stop_y", bus.y, 0);
    cyc();
    chk("stopped_count", bus.count, 0);
    chk("stopped_y", bus.y, 0);
    cyc();
    chk("stop_held_y", bus.y, 0);
    bus.stop = 0;
    cyc();
    chk("restart_y", bus.y, 1);
    chk("restart_count", bus.count, 0);
  endtask
  task automatic test_async_reset;
    rst_dut();
    bus.en = 1; bus.div_load = 1; bus.div_in = 5;
    cyc();
    bus.div_load = 0;
    cyc();
    cyc();
    bus.div_load = 1; bus.div_in = 7;
    cyc();
    bus.div_load = 0;
    #1;
    chk("ar_pre_count", bus.count, 3);
    chk("ar_pre_div", bus.div_cur, 5);
    chk("ar_pre_pend", bus.pend, 1);
    #1;
    reset = 1;
    #1;
    chk("ar_count", bus.count, 0);
    chk("ar_div", bus.div_cur, 3);
    chk("ar_pend", bus.pend, 0);
    chk("ar_y", bus.y, 0);
    chk("ar_tick", bus.tick, 0);
    reset = 0;
    cyc();
    chk("ar_after_div", bus.div_cur, 3);
    chk("ar_after_y", bus.y, 1);
  endtask
  initial begin
    pass_n = 0;
    total_n = 0;
    test_reset();
    test_default_divide();
    test_reload();
    test_reload_edges();
    test_square();
    test_enable_gating();
    test_stop();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule

// File: doc/clk_div_n_fsm.md
# clk_div_n_fsm

Parametrised divide-by-N state machine, the general form of the team's fixed divide-by-3 counter. It produces a periodic output `y` every N enabled clock cycles. N can be changed at runtime through a load port, and the output is either a one-cycle pulse or a near-50% square wave. It sits beside the clock/enable generation logic and feeds clock-enable strobes to slower downstream blocks.

## Interface
- `WIDTH`, default 8: width of the divisor and the phase counter; max N = 2^WIDTH-1.
- `DEFAULT_DIV`, default 3: divisor in effect after reset; must be 1..2^WIDTH-1.

- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high; clock `clk`.
- `en`  in  1  count enable; low freezes the phase.
- `stop`  in  1  synchronous; returns the FSM to IDLE.
- `mode`  in  1  0 = pulse output, 1 = square output; sampled combinationally.
- `div_in`  in  WIDTH  new divisor value.
- `div_load`  in  1  one-cycle strobe; captures `div_in`.
- `y`  out  1  divided output.
- `tick`  out  1  one-cycle strobe on the last phase of each period.
- `count`  out  WIDTH  current phase, 0..N-1.
- `div_cur`  out  WIDTH  divisor currently in effect.
- `pend`  out  1  a loaded divisor is waiting for the period boundary.

## Operation
- States: IDLE, RUN. The phase counter `count` is only meaningful in RUN.
- **Reset:** state=IDLE, count=0, div_cur=DEFAULT_DIV, pend=0, div_pend=0. As a result y=0 and tick=0.
- **IDLE:**
  - en=1 and stop=0 → RUN with count=0.
  - Otherwise stay in IDLE.
- **RUN:**
  - stop=1 → IDLE, count=0. stop has priority over en.
  - en=1 → count = (count==N-1) ? 0 : count+1, where N = div_cur.
  - en=0 → count holds.
- **Divisor load:**
  - A div_load strobe captures div_in into div_pend and sets pend=1.
  - div_in=0 is clamped to 1 at capture.
  - A later load before application overwrites div_pend; last value wins.
- **Divisor application:** div_pend → div_cur and pend cleared, at any of these:
  - the wrap cycle (RUN, en=1, count==N-1);
  - any cycle in IDLE;
  - the cycle stop=1 is taken.
  - If div_load and an application event fall in the same cycle, the newly presented value is the one applied that cycle. pend ends at 0.
- **Outputs** are combinational from registered state. All outputs are 0 in IDLE.
  - Pulse mode (mode=0): y = RUN && count==0.
  - Square mode (mode=1): y = RUN && count < ((N+1)>>1). Example: N=5 gives high 3 cycles, low 2. N=1 gives constantly high.
  - tick = RUN && en && count==N-1 && !stop.
- **Arithmetic:** the count compare is unsigned WIDTH-bit. count never exceeds div_cur-1, because a divisor only changes at count=0 boundaries or in IDLE.

## Timing
- **Start latency:** en asserted in IDLE at edge k → RUN with count=0 visible after edge k. In pulse mode y=1 in that cycle.
- **Steady state:** period is exactly N cycles of en=1. tick and count==N-1 coincide; y (pulse) follows tick by 1 cycle.
- **Divisor change:** takes effect on the first cycle of the next period. The current period always completes at the old N.
- **en low mid-period:** y, count and div_cur freeze. tick=0 while en=0.
- **reset mid-operation:** immediate (asynchronous) return to reset values, including div_cur=DEFAULT_DIV. A pending divisor is discarded.
- **mode change:** takes effect on y in the same cycle; no state change.

## Test plan
- **Reset and default divide:** reset, then en=1 constantly, DEFAULT_DIV=3 → y = 1,0,0,1,0,0…; tick high when count=2; `count` cycles 0,1,2.
- **Runtime reload:** N=3 running; div_load with div_in=5 at count=1 → pend=1 until the wrap. Then div_cur=5, y period 5, pend=0.
- **Reload edge cases:**
  - div_load with div_in=0 → div_cur becomes 1; pulse y and tick high every cycle.
  - Load on the wrap cycle → new N applies immediately at that wrap.
- **Square mode:**
  - mode=1, N=4 → y = 1,1,0,0 repeating.
  - N=5 → y = 1,1,1,0,0.
  - N=1 → y constant 1.
- **Enable gating:** N=3, drop en at count=1 for 4 cycles → count stays 1, y=0, tick=0. On re-enable, count continues to 2, then tick.
- **stop and reset mid-period:**
  - stop at count=2 with tick conditions met → tick=0, next state IDLE, y=0.
  - Asynchronous reset at count=3 with N=5 and pend=1 → immediate IDLE, div_cur=3, pend=0.
